tmr_scrub_reg: RTL and testbench
================================

TMR_SCRUB_REG -- requirements
Module: tmr_scrub_reg

Interface
REQ-001 SHALL have parameter DataWidth, default 32: width of the protected word.
REQ-002 SHALL have parameter VoterType, default 0: per-bit majority style; 0 classical, 1 KP, 2 BN, other values classical; all styles give the same logical result.
REQ-003 SHALL have parameter ScrubPeriod, default 16, legal range >= 1: IDLE cycles between scrub checks.
REQ-004 SHALL have parameter ResetValue, default '0: reset content of all three replicas.
REQ-005 SHALL have parameter CntWidth, default 8: width of the error counter.
REQ-006 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-007 rst_i  input  1  reset, asynchronous, active-high.
REQ-008 wr_valid_i  input  1  write request.
REQ-009 wr_ready_o  output  1  write may be accepted.
REQ-010 wr_data_i  input  DataWidth  write data, copied into all three replicas.
REQ-011 inj_valid_i  input  1  fault-injection strobe.
REQ-012 inj_mask_i  input  3*DataWidth  XOR mask; slice [k*DataWidth +: DataWidth] targets replica k (k=0 A, k=1 B, k=2 C).
REQ-013 data_o  output  DataWidth  per-bit majority of the three replicas.
REQ-014 replica_o  output  3*DataWidth  raw replicas, packed in the same order as inj_mask_i.
REQ-015 corrected_o  output  1  one-cycle pulse during a correction.
REQ-016 fault_mask_o  output  3  bit k set: replica k differed from the vote at the last check.
REQ-017 err_cnt_o  output  CntWidth  saturating correction count.
REQ-018 err_clr_i  input  1  synchronous clear of err_cnt_o.

Function
REQ-019 data_o SHALL be combinational, with zero latency from the replica registers.
REQ-020 A write SHALL be accepted when wr_valid_i and wr_ready_o are both high; all three replicas SHALL hold wr_data_i after that edge.
REQ-021 Injection SHALL XOR inj_mask_i into the replicas on the edge where inj_valid_i is high and no write is accepted.
REQ-022 On a simultaneous write and injection, the write SHALL win and the injection SHALL be dropped.
REQ-023 The FSM SHALL have three states: IDLE, CHECK and CORRECT.
REQ-024 IDLE: the period counter SHALL increment each cycle; when it reaches ScrubPeriod-1 the FSM SHALL go to CHECK and the counter SHALL return to 0.
REQ-025 CHECK (1 cycle): fault_mask_o SHALL be registered from the replica-vs-vote comparison; if the mask is nonzero the FSM SHALL go to CORRECT, otherwise to IDLE.
REQ-026 A write accepted in the CHECK cycle SHALL cancel the correction: the FSM goes to IDLE and fault_mask_o loads 000.
REQ-027 CORRECT (1 cycle): wr_ready_o SHALL be 0, injection SHALL be ignored, all replicas SHALL load data_o at the cycle end, corrected_o SHALL be 1, then the FSM SHALL go to IDLE.
REQ-028 wr_ready_o SHALL be 1 in IDLE and CHECK.
REQ-029 fault_mask_o SHALL hold its value until the next CHECK.
REQ-030 err_cnt_o SHALL increment by 1 per CORRECT cycle and saturate at all-ones.
REQ-031 When err_clr_i coincides with a CORRECT cycle, err_cnt_o SHALL become 0 (clear wins).
REQ-032 With ScrubPeriod=1, the FSM SHALL enter CHECK after every single IDLE cycle.

Reset
REQ-033 While rst_i is high, asynchronously: replicas SHALL be ResetValue, the FSM SHALL be IDLE, the period counter 0, err_cnt_o 0, corrected_o 0, fault_mask_o 000, wr_ready_o 1, data_o ResetValue.
REQ-034 Reset asserted mid-CORRECT SHALL abort the correction, with no count increment.

Configuration
REQ-035 Macro TMR_SCRUB_ERR_CNT_EN defined: the error counter SHALL behave as specified in REQ-030 and REQ-031.
REQ-036 Macro TMR_SCRUB_ERR_CNT_EN undefined: the error counter SHALL be absent, err_cnt_o SHALL be constant 0 and err_clr_i SHALL be ignored; all other behaviour SHALL be unchanged.

Verification
REQ-037 Reset then write 0xA5A5A5A5 -> replica_o = 3x 0xA5A5A5A5 and data_o = 0xA5A5A5A5 on the next cycle; no corrected_o pulse at any check.
REQ-038 Inject 0x00000001 into B -> data_o stays 0xA5A5A5A5; at the next CHECK fault_mask_o=010; a 1-cycle corrected_o pulse follows; B is restored; err_cnt_o=1.
REQ-039 Inject bit 0 into A and bit 31 into C -> data_o unchanged; fault_mask_o=101; a single correction repairs both replicas.
REQ-040 Inject into A, then write 0x12345678 in the CHECK cycle -> no correction; all replicas = 0x12345678; fault_mask_o=000.
REQ-041 With CntWidth=2, perform 5 corrections -> err_cnt_o=3; err_clr_i together with a correction -> err_cnt_o=0; without TMR_SCRUB_ERR_CNT_EN err_cnt_o stays 0 throughout.
REQ-042 Assert rst_i in the CORRECT cycle -> outputs take their reset values immediately and err_cnt_o=0.

Source files
------------

// File: rtl/tmr_scrub_reg.sv
// tmr_scrub_reg -- triple-modular-redundant register with periodic scrubbing.
//
// Three replicas of a DataWidth word are kept. data_o is the per-bit
// majority vote. Every ScrubPeriod idle cycles the replicas are compared
// against the vote (CHECK); on any disagreement the vote is written back
// into all replicas in the following CORRECT cycle.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   wr_valid_i/_ready_o  write handshake, wr_data_i copied to all replicas
//   inj_valid_i          fault-injection strobe, inj_mask_i XORed into the
//                        replicas (slice k*DataWidth targets replica k)
//   data_o               majority vote (combinational)
//   replica_o            raw replicas, same packing as inj_mask_i
//   corrected_o          high during the CORRECT cycle
//   fault_mask_o         replicas that differed from the vote at last CHECK
//   err_cnt_o, err_clr_i saturating correction counter and its clear
//
// Configuration: define TMR_SCRUB_ERR_CNT_EN to build the error counter;
// otherwise err_cnt_o is tied to zero and err_clr_i is ignored.
module tmr_scrub_reg #(
  parameter int unsigned          DataWidth   = 32,
  parameter int unsigned          VoterType   = 0,
  parameter int unsigned          ScrubPeriod = 16,
  parameter logic [DataWidth-1:0] ResetValue  = '0,
  parameter int unsigned          CntWidth    = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_valid_i,
  output logic                   wr_ready_o,
  input  logic [DataWidth-1:0]   wr_data_i,
  input  logic                   inj_valid_i,
  input  logic [3*DataWidth-1:0] inj_mask_i,
  output logic [DataWidth-1:0]   data_o,
  output logic [3*DataWidth-1:0] replica_o,
  output logic                   corrected_o,
  output logic [2:0]             fault_mask_o,
  output logic [CntWidth-1:0]    err_cnt_o,
  input  logic                   err_clr_i
);

  localparam int unsigned PerW = (ScrubPeriod > 1) ? $clog2(ScrubPeriod) : 1;
  localparam logic [PerW-1:0] PerMax = PerW'(ScrubPeriod - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_CHECK,
    S_CORRECT
  } state_e;

  state_e                          state_q, state_d;
  logic [PerW-1:0]                 per_cnt_q, per_cnt_d;
  logic [2:0]                      fault_q, fault_d;
  logic [2:0][DataWidth-1:0]       rep_q, rep_d;
  logic [2:0][DataWidth-1:0]       inj_mask;
  logic [DataWidth-1:0]            vote;
  logic [2:0]                      diff;
  logic                            wr_acc;

  assign inj_mask = inj_mask_i;

  // Voter styles differ only in gate structure; all compute the majority.
  generate
    if (VoterType == 1) begin : g_vote_kp
      assign vote = (rep_q[0] & rep_q[1]) | ((rep_q[0] ^ rep_q[1]) & rep_q[2]);
    end else if (VoterType == 2) begin : g_vote_bn
      // When A and B agree they are the majority, otherwise C breaks the tie.
      assign vote = ((rep_q[0] ~^ rep_q[1]) & rep_q[0]) |
                    ((rep_q[0] ^ rep_q[1]) & rep_q[2]);
    end else begin : g_vote_classic
      assign vote = (rep_q[0] & rep_q[1]) | (rep_q[0] & rep_q[2]) |
                    (rep_q[1] & rep_q[2]);
    end
  endgenerate

  always_comb begin
    diff = '0;
    for (int unsigned k = 0; k < 3; k++) begin
      diff[k] = |(rep_q[k] ^ vote);
    end
  end

  assign wr_ready_o   = (state_q != S_CORRECT);
  assign corrected_o  = (state_q == S_CORRECT);
  assign wr_acc       = wr_valid_i & wr_ready_o;
  assign data_o       = vote;
  assign replica_o    = rep_q;
  assign fault_mask_o = fault_q;

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    fault_d   = fault_q;
    rep_d     = rep_q;

    unique case (state_q)
      S_IDLE: begin
        if (per_cnt_q == PerMax) begin
          state_d   = S_CHECK;
          per_cnt_d = '0;
        end else begin
          per_cnt_d = per_cnt_q + 1'b1;
        end
      end
      S_CHECK: begin
        // A write in this cycle overwrites all replicas, so any pending
        // correction is moot.
        if (wr_acc) begin
          fault_d = '0;
          state_d = S_IDLE;
        end else begin
          fault_d = diff;
          state_d = (diff != 3'b000) ? S_CORRECT : S_IDLE;
        end
      end
      S_CORRECT: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase

    if (wr_acc) begin
      rep_d = {3{wr_data_i}};
    end else if (state_q == S_CORRECT) begin
      rep_d = {3{vote}};
    end else if (inj_valid_i) begin
      rep_d = rep_q ^ inj_mask;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      per_cnt_q <= '0;
      fault_q   <= '0;
      rep_q     <= {3{ResetValue}};
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      fault_q   <= fault_d;
      rep_q     <= rep_d;
    end
  end

`ifdef TMR_SCRUB_ERR_CNT_EN
  logic [CntWidth-1:0] err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (err_clr_i) begin
      err_cnt_q <= '0;
    end else if ((state_q == S_CORRECT) && (err_cnt_q != '1)) begin
      err_cnt_q <= err_cnt_q + 1'b1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr_i;
  assign err_cnt_o      = '0;
`endif

endmodule

// File: tb/tb_tmr_scrub_reg.sv
// Bench for tmr_scrub_reg: three instances (two voter styles at period 4,
// one at period 1 with a nonzero reset value) share one stimulus stream and
// are compared every cycle against a behavioural model.
module tb_tmr_scrub_reg;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          wr_valid;
  logic [W-1:0]  wr_data;
  logic          inj_valid;
  logic [3*W-1:0] inj_mask;
  logic          err_clr;

  logic          ready_w   [3];
  logic [W-1:0]  data_w    [3];
  logic [3*W-1:0] rep_w    [3];
  logic          corr_w    [3];
  logic [2:0]    fm_w      [3];
  logic [1:0]    err_w     [3];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tmr_scrub_reg #(.DataWidth(W), .VoterType(0), .ScrubPeriod(4),
                  .ResetValue(32'h0), .CntWidth(2)) u0 (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(ready_w[0]),
    .wr_data_i(wr_data), .inj_valid_i(inj_valid), .inj_mask_i(inj_mask),
    .data_o(data_w[0]), .replica_o(rep_w[0]), .corrected_o(corr_w[0]),
    .fault_mask_o(fm_w[0]), .err_cnt_o(err_w[0]), .err_clr_i(err_clr));

  tmr_scrub_reg #(.DataWidth(W), .VoterType(1), .ScrubPeriod(4),
                  .ResetValue(32'h0), .CntWidth(2)) u1 (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(ready_w[1]),
    .wr_data_i(wr_data), .inj_valid_i(inj_valid), .inj_mask_i(inj_mask),
    .data_o(data_w[1]), .replica_o(rep_w[1]), .corrected_o(corr_w[1]),
    .fault_mask_o(fm_w[1]), .err_cnt_o(err_w[1]), .err_clr_i(err_clr));

  tmr_scrub_reg #(.DataWidth(W), .VoterType(2), .ScrubPeriod(1),
                  .ResetValue(32'h0F0F_0000), .CntWidth(2)) u2 (
    .clk_i(clk), .rst_i(rst), .wr_valid_i(wr_valid), .wr_ready_o(ready_w[2]),
    .wr_data_i(wr_data), .inj_valid_i(inj_valid), .inj_mask_i(inj_mask),
    .data_o(data_w[2]), .replica_o(rep_w[2]), .corrected_o(corr_w[2]),
    .fault_mask_o(fm_w[2]), .err_cnt_o(err_w[2]), .err_clr_i(err_clr));

  // Model: per instance, three replica words, a phase (0 idle, 1 check,
  // 2 correct), idle cycle count, last fault mask and correction count.
  logic [W-1:0] m_rep [3][3];
  int           m_ph  [3];
  int           m_idle[3];
  logic [2:0]   m_fm  [3];
  int           m_err [3];
  int           period[3] = '{4, 4, 1};
  logic [W-1:0] rstv  [3] = '{32'h0, 32'h0, 32'h0F0F_0000};

  function automatic logic [W-1:0] maj(input logic [W-1:0] a, b, c);
    logic [W-1:0] r;
    for (int n = 0; n < W; n++) begin
      int ones;
      ones = int'(a[n]) + int'(b[n]) + int'(c[n]);
      r[n] = (ones >= 2);
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      for (int k = 0; k < 3; k++) m_rep[i][k] = rstv[i];
      m_ph[i] = 0; m_idle[i] = 0; m_fm[i] = 3'b000; m_err[i] = 0;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < 3; i++) begin
      logic [W-1:0] v;
      logic         wr;
      int           ph;
      ph = m_ph[i];
      wr = wr_valid && (ph != 2);
      v  = maj(m_rep[i][0], m_rep[i][1], m_rep[i][2]);
      if (ph == 0) begin
        if (m_idle[i] + 1 >= period[i]) begin m_ph[i] = 1; m_idle[i] = 0; end
        else m_idle[i]++;
      end else if (ph == 1) begin
        for (int k = 0; k < 3; k++) m_fm[i][k] = (m_rep[i][k] != v);
        if (wr) m_fm[i] = 3'b000;
        m_ph[i] = (m_fm[i] != 0) ? 2 : 0;
      end else begin
        m_ph[i] = 0;
        if (m_err[i] < 3) m_err[i]++;
      end
      if (err_clr) m_err[i] = 0;
      for (int k = 0; k < 3; k++) begin
        if (wr)                m_rep[i][k] = wr_data;
        else if (ph == 2)      m_rep[i][k] = v;
        else if (inj_valid)    m_rep[i][k] = m_rep[i][k] ^ inj_mask[k*W +: W];
      end
    end
  endtask

  task automatic chk(input string tag, input int i, input logic [3*W-1:0] obs,
                     input logic [3*W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[%0d] got %h want %h", tag, i, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      int e;
`ifdef TMR_SCRUB_ERR_CNT_EN
      e = m_err[i];
`else
      e = 0;
`endif
      chk("data", i, {64'h0, data_w[i]}, {64'h0, maj(m_rep[i][0], m_rep[i][1], m_rep[i][2])});
      chk("replica", i, rep_w[i], {m_rep[i][2], m_rep[i][1], m_rep[i][0]});
      chk("fault_mask", i, {93'h0, fm_w[i]}, {93'h0, m_fm[i]});
      chk("corrected", i, {95'h0, corr_w[i]}, {95'h0, (m_ph[i] == 2)});
      chk("ready", i, {95'h0, ready_w[i]}, {95'h0, (m_ph[i] != 2)});
      chk("err_cnt", i, {94'h0, err_w[i]}, 96'(e));
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check_all();
  endtask

  task automatic idle(input int n);
    for (int j = 0; j < n; j++) cyc();
  endtask

  // Advance until instance 0 is about to sample in the given phase.
  task automatic wait_phase(input int ph);
    int n;
    n = 0;
    while (m_ph[0] != ph && n < 20) begin cyc(); n++; end
    chk("wait_phase", ph, 96'(n < 20), 96'(1));
  endtask

  task automatic inject(input logic [3*W-1:0] m);
    inj_valid = 1'b1; inj_mask = m;
    cyc();
    inj_valid = 1'b0; inj_mask = '0;
  endtask

  task automatic write(input logic [W-1:0] d);
    wr_valid = 1'b1; wr_data = d;
    cyc();
    wr_valid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_valid = 1'b0; wr_data = '0;
    inj_valid = 1'b0; inj_mask = '0; err_clr = 1'b0;
    #1;
    model_reset();
    check_all();
    idle(2);
    rst = 1'b0;

    write(32'hA5A5_A5A5);
    idle(10);

    inject(96'h1 << 32);                       // bit 0 of B
    idle(8);

    inject((96'h1) | (96'h1 << 95));           // bit 0 of A, bit 31 of C
    idle(8);

    wait_phase(0);
    inject(96'h20);                            // bit 5 of A
    wait_phase(1);
    write(32'h1234_5678);                      // lands in the CHECK cycle
    idle(6);

    for (int r = 0; r < 5; r++) begin
      inject(96'h1 << (64 + $urandom_range(31)));
      idle(6);
    end

    wait_phase(0);
    inject(96'h1 << 40);
    wait_phase(2);
    err_clr = 1'b1;
    cyc();
    err_clr = 1'b0;
    idle(4);

    for (int r = 0; r < 2; r++) begin
      inject(96'h1 << 33);
      idle(6);
    end
    wait_phase(0);
    inject(96'h1 << 7);
    wait_phase(2);
    rst = 1'b1;
    #1;
    model_reset();
    check_all();
    cyc();
    rst = 1'b0;
    idle(3);

    for (int r = 0; r < 400; r++) begin
      wr_valid  = ($urandom_range(7) == 0);
      wr_data   = $urandom;
      inj_valid = ($urandom_range(3) == 0);
      inj_mask  = '0;
      if ($urandom_range(3) == 0) inj_mask = {$urandom, $urandom, $urandom};
      else inj_mask[$urandom_range(3*W-1)] = 1'b1;
      err_clr   = ($urandom_range(15) == 0);
      cyc();
    end
    wr_valid = 1'b0; inj_valid = 1'b0; err_clr = 1'b0;
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
